// File: rtl/float_add_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : float_add_arbiter_pkg
// Brief    : Shared float format widths and arbiter state encoding.
// Revision : 1.0
// ============================================================================
package float_add_arbiter_pkg;

    localparam int float_exp_width  = 8;
    localparam int float_mant_width = 23;
    localparam int float_width      = 1 + float_exp_width + float_mant_width;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } e_float_arb_state;

endpackage
`default_nettype wire

// File: rtl/float_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : float_arb_rr_pick
// Brief    : Combinational round-robin picker; scans upward from last_grant+1.
// Revision : 1.0
// ============================================================================
module float_arb_rr_pick
    import float_add_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               any_valid_o
);

    int   idx;
    logic found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_i) + k) % NUM_REQ;
            if (!found && req_i[idx[IDX_W-1:0]]) begin
                found   = 1'b1;
                grant_o = idx[IDX_W-1:0];
            end
        end
        any_valid_o = |req_i;
    end

endmodule
`default_nettype wire

// File: rtl/float_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : float_add_arbiter
// Brief    : Round-robin arbiter sharing one float adder among NUM_REQ users.
//            Optional watchdog enabled by macro FLOAT_ADD_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module float_add_arbiter
    import float_add_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*float_width-1:0] req_a,
    input  logic [NUM_REQ*float_width-1:0] req_b,
    output logic [NUM_REQ-1:0]             resp_ack,
    output logic [float_width-1:0]         resp_out,
    output logic                           resp_err,
    output logic                           fadd_req,
    output logic [float_width-1:0]         fadd_a,
    output logic [float_width-1:0]         fadd_b,
    input  logic                           fadd_ack,
    input  logic [float_width-1:0]         fadd_out,
    output logic                           busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);

    e_float_arb_state       state_q, state_d;
    logic                   fadd_req_q, fadd_req_d;
    logic [float_width-1:0] fadd_a_q, fadd_a_d;
    logic [float_width-1:0] fadd_b_q, fadd_b_d;
    logic [NUM_REQ-1:0]     resp_ack_q, resp_ack_d;
    logic [float_width-1:0] resp_out_q, resp_out_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       last_grant_q, last_grant_d;
    logic                   busy_q, busy_d;
    logic                   resp_err_d;

    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;

`ifdef FLOAT_ADD_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             resp_err_q;
`endif

    float_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_idx),
        .any_valid_o  (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        fadd_req_d   = 1'b0;
        fadd_a_d     = fadd_a_q;
        fadd_b_d     = fadd_b_q;
        resp_ack_d   = '0;
        resp_out_d   = '0;
        resp_err_d   = 1'b0;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
`ifdef FLOAT_ADD_ARB_TIMEOUT_EN
        cnt_d        = '0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d    = pick_idx;
                    fadd_a_d   = req_a[int'(pick_idx)*float_width +: float_width];
                    fadd_b_d   = req_b[int'(pick_idx)*float_width +: float_width];
                    fadd_req_d = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // The ack is checked first so it wins over a coincident expiry.
                if (fadd_ack) begin
                    resp_ack_d   = ONE_HOT_0 << grant_q;
                    resp_out_d   = fadd_out;
                    last_grant_d = grant_q;
                    state_d      = RESP;
                end
`ifdef FLOAT_ADD_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    resp_ack_d   = ONE_HOT_0 << grant_q;
                    resp_err_d   = 1'b1;
                    last_grant_d = grant_q;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            // RESP ignores req_valid so a requester dropping valid on its ack
            // edge can never be re-issued.
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fadd_req_q   <= 1'b0;
            fadd_a_q     <= '0;
            fadd_b_q     <= '0;
            resp_ack_q   <= '0;
            resp_out_q   <= '0;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fadd_req_q   <= fadd_req_d;
            fadd_a_q     <= fadd_a_d;
            fadd_b_q     <= fadd_b_d;
            resp_ack_q   <= resp_ack_d;
            resp_out_q   <= resp_out_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
        end
    end

`ifdef FLOAT_ADD_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            resp_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            resp_err_q <= resp_err_d;
        end
    end
    assign resp_err = resp_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = resp_err_d ^ (TIMEOUT_CYCLES > 0);
    assign resp_err       = 1'b0;
`endif

    assign fadd_req = fadd_req_q;
    assign fadd_a   = fadd_a_q;
    assign fadd_b   = fadd_b_q;
    assign resp_ack = resp_ack_q;
    assign resp_out = resp_out_q;
    assign busy     = busy_q;

`ifndef SYNTHESIS
    a_inputs_known: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({req_valid, fadd_ack}));
`endif

endmodule
`default_nettype wire
